// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared definitions for the round-robin input arbiter:
//               buffer state encoding, default widths and a clog2 helper.
// Contents    : state_t (ST_EMPTY / ST_FULL), ARB_DW, ARB_N_REQ, arb_clog2()
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

  // Output buffer occupancy.
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam int ARB_DW    = 2;
  localparam int ARB_N_REQ = 4;

  // Ceiling log2, never less than 1 so a 2-requester build keeps a 1-bit index.
  function automatic int arb_clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin pick. Rotates the request vector so
//               rr_ptr sits at position 0, takes the lowest set bit, then maps
//               the offset back to an absolute requester index.
// Ports       : req_valid    in  N_REQ  request vector
//               rr_ptr       in  SW     highest-priority requester
//               grant_onehot out N_REQ  one-hot winner (zero when none)
//               grant_idx    out SW     winner index (valid when any=1)
//               any          out 1      at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int SW    = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [SW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] grant_onehot,
  output logic [SW-1:0]    grant_idx,
  output logic             any
);

  // (a + b) mod N_REQ for a < N_REQ and b < N_REQ; works for non-power-of-2 N_REQ.
  function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= N_REQ) begin
      s = s - N_REQ;
    end
    return SW'(s);
  endfunction

  logic [N_REQ-1:0] w_rot;
  logic [SW-1:0]    w_off;
  logic             w_hit;

  always_comb begin
    w_rot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_rot[k] = req_valid[wrap_add(rr_ptr, k)];
    end
  end

  // Scan downward so the lowest rotated position wins.
  always_comb begin
    w_off = '0;
    w_hit = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = SW'(k);
        w_hit = 1'b1;
      end
    end
  end

  always_comb begin
    grant_idx    = wrap_add(rr_ptr, int'(w_off));
    grant_onehot = w_hit ? (N_REQ'(1) << grant_idx) : '0;
    any          = w_hit;
  end

endmodule
`default_nettype wire

// File: rtl/rr_in_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_in_arbiter
// Description : Round-robin arbiter feeding a single-entry output buffer.
//               Each load records data and source index; each pop by the
//               consumer bumps a wrapping transfer counter.
// Ports       : sys_clk   in  1         clock, rising edge
//               sys_rst   in  1         asynchronous active-high reset
//               req_valid in  N_REQ     per-requester valid
//               req_data  in  N_REQ*DW  packed data, requester 0 in LSBs
//               req_ready out N_REQ     one-hot grant
//               out       out DW        buffered data
//               out_valid out 1         buffer occupied
//               out_src   out SW        source of buffered data
//               out_ready in  1         consumer accept
//               xfer_cnt  out CNTW      completed pops, wrapping
// Revision    : 1.0 - initial release
// ============================================================================
module rr_in_arbiter
  import arb_pkg::*;
#(
  parameter  int N_REQ = ARB_N_REQ,
  parameter  int DW    = ARB_DW,
  parameter  int CNTW  = 16,
  localparam int SW    = arb_clog2(N_REQ)
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic [DW-1:0]       out,
  output logic                out_valid,
  output logic [SW-1:0]       out_src,
  input  logic                out_ready,
  output logic [CNTW-1:0]     xfer_cnt
);

  state_t          r_state;
  logic [DW-1:0]   r_out;
  logic            r_out_valid;
  logic [SW-1:0]   r_out_src;
  logic [CNTW-1:0] r_xfer_cnt;
  logic [SW-1:0]   r_rr_ptr;

  logic [N_REQ-1:0] w_grant_onehot;
  logic [SW-1:0]    w_grant_idx;
  logic             w_any;
  logic             w_can_load;
  logic             w_load;
  logic             w_pop;
  logic [DW-1:0]    w_win_data;
  logic [SW-1:0]    w_ptr_next;

  rr_pick #(
    .N_REQ (N_REQ),
    .SW    (SW)
  ) u_pick (
    .req_valid    (req_valid),
    .rr_ptr       (r_rr_ptr),
    .grant_onehot (w_grant_onehot),
    .grant_idx    (w_grant_idx),
    .any          (w_any)
  );

  // A full buffer can still accept when the consumer drains it this cycle,
  // which keeps throughput at one transfer per cycle.
  assign w_can_load = (r_state == ST_EMPTY) | out_ready;
  assign req_ready  = w_can_load ? w_grant_onehot : '0;
  assign w_load     = w_can_load & w_any;
  assign w_pop      = r_out_valid & out_ready;
  assign w_win_data = req_data[int'(w_grant_idx)*DW +: DW];
  assign w_ptr_next = (w_grant_idx == SW'(N_REQ - 1)) ? '0 : w_grant_idx + SW'(1);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= ST_EMPTY;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_out_src   <= '0;
      r_xfer_cnt  <= '0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_load) begin
        r_state     <= ST_FULL;
        r_out       <= w_win_data;
        r_out_src   <= w_grant_idx;
        r_out_valid <= 1'b1;
        r_rr_ptr    <= w_ptr_next;
      end else if (w_pop) begin
        // Data is left in place; only the valid flag drops.
        r_state     <= ST_EMPTY;
        r_out_valid <= 1'b0;
      end
      if (w_pop) begin
        r_xfer_cnt <= r_xfer_cnt + CNTW'(1);
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign out_src   = r_out_src;
  assign xfer_cnt  = r_xfer_cnt;

endmodule
`default_nettype wire
